spmv_perf_stats: RTL

Downstream consumer of the SpMV kernel cycle timer. The timer exposes a free-running cumulative busy-cycle count that clears only on reset. This block detects each run's end strobe and waits for the count to settle. It then derives the per-run duration as the difference from the previous snapshot and maintains run count, last, min and max statistics. Host/control logic reads the statistics through a simple registered read port.

---
 rtl/spmv_perf_pkg.sv | 20 ++
 rtl/spmv_perf_edge.sv | 22 ++
 rtl/spmv_perf_stats.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spmv_perf_pkg.sv
// Shared definitions for the SpMV run statistics block: FSM states,
// register addresses and the default settle delay.
package spmv_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_RUNS   = 3'd0;
    localparam logic [2:0] ADDR_LAST   = 3'd1;
    localparam logic [2:0] ADDR_MIN    = 3'd2;
    localparam logic [2:0] ADDR_MAX    = 3'd3;
    localparam logic [2:0] ADDR_BASE   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int SETTLE_CYC_DEFAULT = 2;

endpackage

// File: rtl/spmv_perf_edge.sv
// Registered rising-edge detector: o_edge is high in the first cycle
// that i_sig is seen high after being low.
module spmv_perf_edge (
    input  logic clk,
    input  logic rstn,
    input  logic i_sig,
    output logic o_edge
);

    logic r_sig_ff;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sig_ff <= 1'b0;
        end else begin
            r_sig_ff <= i_sig;
        end
    end

    assign o_edge = i_sig & ~r_sig_ff;

endmodule

// File: rtl/spmv_perf_stats.sv
// Per-run duration statistics derived from the cumulative SpMV busy-cycle
// timer, with a registered host read port.
module spmv_perf_stats
    import spmv_perf_pkg::*;
#(
    parameter int CNT_W      = 64,
    parameter int RUNS_W     = 32,
    parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CNT_W-1:0] time_use,
    input  logic             end_sig,
    input  logic             stats_clear,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             busy
);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_settle_cnt;
    logic [3:0]          w_settle_next;
    logic                w_end_edge;
    logic                w_busy;
    logic                w_do_update;
    logic [CNT_W-1:0]    w_dur;
    logic [CNT_W-1:0]    w_rd_mux;

    logic [RUNS_W-1:0]   r_run_cnt;
    logic [CNT_W-1:0]    r_last_dur;
    logic [CNT_W-1:0]    r_min_dur;
    logic [CNT_W-1:0]    r_max_dur;
    logic [CNT_W-1:0]    r_base_snap;
    logic                r_overrun;
    logic                r_rd_valid;
    logic [CNT_W-1:0]    r_rd_data;

    spmv_perf_edge u_end_edge (
        .clk    (clk),
        .rstn   (rstn),
        .i_sig  (end_sig),
        .o_edge (w_end_edge)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        if (stats_clear) begin
            w_state_next  = ST_IDLE;
            w_settle_next = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_end_edge) begin
                        w_state_next  = ST_SETTLE;
                        w_settle_next = 4'(SETTLE_CYC - 1);
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        w_state_next = ST_UPDATE;
                    end else begin
                        w_settle_next = r_settle_cnt - 4'd1;
                    end
                end
                ST_UPDATE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign w_busy      = (r_state != ST_IDLE);
    assign w_do_update = (r_state == ST_UPDATE) && !stats_clear;
    // Unsigned subtract stays correct across a wrap of the cumulative count.
    assign w_dur       = time_use - r_base_snap;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_run_cnt   <= '0;
            r_last_dur  <= '0;
            r_min_dur   <= '1;
            r_max_dur   <= '0;
            r_base_snap <= '0;
            r_overrun   <= 1'b0;
        end else if (stats_clear) begin
            r_run_cnt   <= '0;
            r_last_dur  <= '0;
            r_min_dur   <= '1;
            r_max_dur   <= '0;
            r_base_snap <= time_use;
            r_overrun   <= 1'b0;
        end else begin
            if (w_do_update) begin
                r_last_dur  <= w_dur;
                r_base_snap <= time_use;
                if (w_dur < r_min_dur) begin
                    r_min_dur <= w_dur;
                end
                if (w_dur > r_max_dur) begin
                    r_max_dur <= w_dur;
                end
                if (r_run_cnt != '1) begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                end
            end
            // A run ending while the previous one is still being sampled is lost.
            if (w_end_edge && w_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            ADDR_RUNS:   w_rd_mux = CNT_W'(r_run_cnt);
            ADDR_LAST:   w_rd_mux = r_last_dur;
            ADDR_MIN:    w_rd_mux = (r_run_cnt == '0) ? '0 : r_min_dur;
            ADDR_MAX:    w_rd_mux = r_max_dur;
            ADDR_BASE:   w_rd_mux = r_base_snap;
            ADDR_STATUS: w_rd_mux = CNT_W'({r_overrun, w_busy});
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign busy     = w_busy;

endmodule
